// File: rtl/mips_branch_pkg.sv
// Shared branch-type encodings and 2-bit counter helpers for the branch resolve path.
package mips_branch_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLEZ = 3'b010,
        BR_BGTZ = 3'b011,
        BR_BLTZ = 3'b100,
        BR_BGEZ = 3'b101,
        BR_NONE = 3'b110
    } br_type_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: async read, sync update, sync reset.
module bht_2bit
    import mips_branch_pkg::*;
#(
    parameter int unsigned IDX_BITS  = 6,
    parameter logic [1:0]  RESET_CTR = WNT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int unsigned Entries = 2 ** IDX_BITS;

    logic [1:0] ctr_q [Entries];

    // No bypass: a same-cycle write is only visible to reads after the edge.
    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Entries); i++) begin
                ctr_q[i] <= RESET_CTR;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= sat_next(ctr_q[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage conditional branches, trains the BHT and issues a registered redirect/flush.
module branch_resolve_unit
    import mips_branch_pkg::*;
#(
    parameter int unsigned IDX_BITS  = 6,
    parameter logic [1:0]  RESET_CTR = WNT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] IF_PC,
    output logic        PredTaken,
    input  logic        Stall,
    input  logic        BrValid,
    input  logic [2:0]  BrType,
    input  logic [31:0] BrPC,
    input  logic [31:0] BrTarget,
    input  logic        BrPredTaken,
    input  logic        Zero,
    input  logic        Sign,
    output logic        Redirect,
    output logic [31:0] RedirectPC,
    output logic [31:0] BranchCount,
    output logic [31:0] MissCount
);

    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] branch_count_q;
    logic [31:0] miss_count_q;
    logic        taken;
    logic        is_branch;
    logic        accept;
    logic        mispredict;
    logic [31:0] fall_through;
    logic [1:0]  pred_ctr;
    logic        unused_bits;

    always_comb begin
        taken = 1'b0;
        case (BrType)
            BR_BEQ:  taken = Zero;
            BR_BNE:  taken = ~Zero;
            BR_BLEZ: taken = Sign | Zero;
            BR_BGTZ: taken = ~Sign & ~Zero;
            BR_BLTZ: taken = Sign;
            BR_BGEZ: taken = ~Sign;
            default: taken = 1'b0;
        endcase
    end

    assign is_branch    = (BrType <= BR_BGEZ);
    // Anything in EX while the redirect is out is wrong-path and must be dropped.
    assign accept       = BrValid & ~Stall & ~redirect_q & is_branch;
    assign mispredict   = accept & (taken != BrPredTaken);
    assign fall_through = BrPC + 32'd4;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            redirect_q     <= 1'b0;
            redirect_pc_q  <= 32'd0;
            branch_count_q <= 32'd0;
            miss_count_q   <= 32'd0;
        end else begin
            redirect_q <= 1'b0;
            if (accept) begin
                branch_count_q <= branch_count_q + 32'd1;
            end
            if (mispredict) begin
                miss_count_q  <= miss_count_q + 32'd1;
                redirect_q    <= 1'b1;
                redirect_pc_q <= taken ? BrTarget : fall_through;
            end
        end
    end

    bht_2bit #(
        .IDX_BITS  (IDX_BITS),
        .RESET_CTR (RESET_CTR)
    ) u_bht (
        .clk      (Clk),
        .rst      (Rst),
        .rd_idx   (IF_PC[IDX_BITS+1:2]),
        .rd_ctr   (pred_ctr),
        .wr_en    (accept),
        .wr_idx   (BrPC[IDX_BITS+1:2]),
        .wr_taken (taken)
    );

    assign PredTaken   = pred_ctr[1];
    assign Redirect    = redirect_q;
    assign RedirectPC  = redirect_pc_q;
    assign BranchCount = branch_count_q;
    assign MissCount   = miss_count_q;

    assign unused_bits = ^{IF_PC[31:IDX_BITS+2], IF_PC[1:0], pred_ctr[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] IF_PC;
    logic        PredTaken;
    logic        Stall;
    logic        BrValid;
    logic [2:0]  BrType;
    logic [31:0] BrPC;
    logic [31:0] BrTarget;
    logic        BrPredTaken;
    logic        Zero;
    logic        Sign;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] BranchCount;
    logic [31:0] MissCount;

    always #5 Clk = ~Clk;

    branch_resolve_unit dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .IF_PC       (IF_PC),
        .PredTaken   (PredTaken),
        .Stall       (Stall),
        .BrValid     (BrValid),
        .BrType      (BrType),
        .BrPC        (BrPC),
        .BrTarget    (BrTarget),
        .BrPredTaken (BrPredTaken),
        .Zero        (Zero),
        .Sign        (Sign),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .BranchCount (BranchCount),
        .MissCount   (MissCount)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counters as plain ints, redirect as a flag + PC.
    int          m_bht [64];
    bit          m_valid = 1'b0;
    logic        m_redirect;
    logic [31:0] m_rpc;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    function automatic bit branch_taken(input logic [2:0] t, input logic z, input logic s);
        case (t)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return s || z;
            3'd3:    return !s && !z;
            3'd4:    return s;
            3'd5:    return !s;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge Clk) begin
        bit acc;
        bit tk;
        int idx;
        if (Rst) begin
            m_valid    <= 1'b1;
            m_redirect <= 1'b0;
            m_rpc      <= 32'd0;
            m_bc       <= 32'd0;
            m_mc       <= 32'd0;
            for (int i = 0; i < 64; i++) m_bht[i] <= 1;
        end else begin
            acc = BrValid && !Stall && !m_redirect && (BrType < 3'd6);
            m_redirect <= 1'b0;
            if (acc) begin
                tk  = branch_taken(BrType, Zero, Sign);
                idx = int'(BrPC[7:2]);
                m_bc <= m_bc + 32'd1;
                if (tk != BrPredTaken) begin
                    m_mc       <= m_mc + 32'd1;
                    m_redirect <= 1'b1;
                    m_rpc      <= tk ? BrTarget : BrPC + 32'd4;
                end
                m_bht[idx] <= tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                 : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
            end
        end
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            check("model_redirect", Redirect, m_redirect);
            check("model_redirect_pc", RedirectPC, m_rpc);
            check("model_branch_count", BranchCount, m_bc);
            check("model_miss_count", MissCount, m_mc);
            check("model_pred_taken", PredTaken, m_bht[int'(IF_PC[7:2])] >= 2);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic br(input logic v, input logic [2:0] t, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic pred, input logic z, input logic s);
        BrValid     = v;
        BrType      = t;
        BrPC        = pc;
        BrTarget    = tgt;
        BrPredTaken = pred;
        Zero        = z;
        Sign        = s;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        Rst   = 1'b1;
        Stall = 1'b0;
        IF_PC = 32'h100;
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_redirect", Redirect, 1'b0);
        check("reset_redirect_pc", RedirectPC, 32'd0);
        check("reset_branch_count", BranchCount, 32'd0);
        check("reset_miss_count", MissCount, 32'd0);
        check("reset_pred", PredTaken, 1'b0);
        Rst = 1'b0;

        // beq taken, predicted not-taken
        br(1'b1, 3'd0, 32'h100, 32'h200, 1'b0, 1'b1, 1'b0);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("beq_redirect", Redirect, 1'b1);
        check("beq_redirect_pc", RedirectPC, 32'h200);
        check("beq_miss_count", MissCount, 32'd1);
        check("beq_pred_after", PredTaken, 1'b1);
        tick();
        check("beq_pulse_one_cycle", Redirect, 1'b0);

        // bne not taken, predicted taken; duplicate in redirect cycle is wrong-path
        do_reset();
        br(1'b1, 3'd1, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0);
        tick();
        check("bne_redirect", Redirect, 1'b1);
        check("bne_redirect_pc", RedirectPC, 32'h44);
        check("bne_miss_count", MissCount, 32'd1);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("wrongpath_branch_count", BranchCount, 32'd1);
        check("wrongpath_miss_count", MissCount, 32'd1);
        check("wrongpath_redirect", Redirect, 1'b0);

        // sign-based branches, all predicted not-taken
        tick();
        br(1'b1, 3'd2, 32'h400, 32'h480, 1'b0, 1'b1, 1'b0);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("blez_redirect", Redirect, 1'b1);
        check("blez_redirect_pc", RedirectPC, 32'h480);
        tick();
        br(1'b1, 3'd3, 32'h404, 32'h4C0, 1'b0, 1'b0, 1'b0);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("bgtz_redirect", Redirect, 1'b1);
        check("bgtz_redirect_pc", RedirectPC, 32'h4C0);
        tick();
        br(1'b1, 3'd4, 32'h408, 32'h500, 1'b0, 1'b0, 1'b0);
        tick();
        check("bltz_no_redirect", Redirect, 1'b0);
        br(1'b1, 3'd5, 32'h40C, 32'h540, 1'b0, 1'b0, 1'b1);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("bgez_no_redirect", Redirect, 1'b0);
        check("sign_branch_count", BranchCount, 32'd5);
        check("sign_miss_count", MissCount, 32'd3);

        // saturation at BrPC=0x10: predictions 0,1,1,1 track the counter 01->10->11->11->11
        do_reset();
        IF_PC = 32'h10;
        br(1'b1, 3'd0, 32'h10, 32'h90, 1'b0, 1'b1, 1'b0);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("sat_first_redirect", Redirect, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            br(1'b1, 3'd0, 32'h10, 32'h90, 1'b1, 1'b1, 1'b0);
            tick();
            check("sat_no_redirect", Redirect, 1'b0);
        end
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("sat_branch_count", BranchCount, 32'd4);
        check("sat_miss_count", MissCount, 32'd1);
        // one not-taken step from 11 must still predict taken
        br(1'b1, 3'd0, 32'h10, 32'h90, 1'b1, 1'b0, 1'b0);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("sat_after_one_down", PredTaken, 1'b1);
        check("sat_nt_redirect_pc", RedirectPC, 32'h14);

        // stall holds the branch for 3 cycles
        do_reset();
        Stall = 1'b1;
        br(1'b1, 3'd0, 32'h300, 32'h500, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_no_redirect", Redirect, 1'b0);
            check("stall_branch_count", BranchCount, 32'd0);
        end
        Stall = 1'b0;
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("unstall_redirect", Redirect, 1'b1);
        check("unstall_redirect_pc", RedirectPC, 32'h500);
        check("unstall_branch_count", BranchCount, 32'd1);
        tick();
        check("unstall_pulse_end", Redirect, 1'b0);
        check("unstall_miss_count", MissCount, 32'd1);

        // reset wins over a mispredicting accept
        IF_PC = 32'h0;
        br(1'b1, 3'd0, 32'h0, 32'h600, 1'b0, 1'b1, 1'b0);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        Rst = 1'b1;
        br(1'b1, 3'd0, 32'h0, 32'h700, 1'b0, 1'b1, 1'b0);
        tick();
        Rst = 1'b0;
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("rst_prio_redirect", Redirect, 1'b0);
        check("rst_prio_branch_count", BranchCount, 32'd0);
        check("rst_prio_miss_count", MissCount, 32'd0);
        check("rst_prio_redirect_pc", RedirectPC, 32'd0);
        check("rst_prio_pred", PredTaken, 1'b0);
        br(1'b1, 3'd0, 32'h8, 32'h1234, 1'b0, 1'b1, 1'b0);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("pre_wrap_redirect_pc", RedirectPC, 32'h1234);
        tick();
        br(1'b1, 3'd0, 32'hFFFF_FFFC, 32'h2000, 1'b1, 1'b0, 1'b0);
        tick();
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("wrap_redirect", Redirect, 1'b1);
        check("wrap_redirect_pc", RedirectPC, 32'h0);

        // randomized traffic on a few BHT indices to force collisions
        for (int c = 0; c < 3000; c++) begin
            Rst   = ($urandom_range(0, 199) == 0);
            Stall = ($urandom_range(0, 4) == 0);
            IF_PC = ($urandom & 32'hF000_0003) | (32'($urandom_range(0, 7)) << 2);
            br(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
               ($urandom & 32'hF000_0000) | (32'($urandom_range(0, 7)) << 2) |
               (32'($urandom_range(0, 1)) << 8),
               $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        Rst = 1'b0;
        br(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumes the one-bit zero flag from the EX-stage zero comparator. That flag is taken on rs-rt for beq/bne and on rs for the sign-based branches.
- Resolves conditional branches, detects mispredictions, and issues a registered PC redirect plus a pipeline flush.
- Holds a 2-bit saturating branch history table (BHT), which the IF stage reads for a taken/not-taken prediction.
- Sits between the EX-stage comparator and the PC-select mux.

Parameters:
- IDX_BITS, 6, BHT index width (2^IDX_BITS entries), indexed by PC[IDX_BITS+1:2].
- RESET_CTR, 2'b01, reset value of every BHT counter (weakly not-taken).

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  synchronous reset, active-high.
- IF_PC  input  32  fetch-stage PC for prediction lookup.
- PredTaken  output  1  combinational: BHT[IF_PC[IDX_BITS+1:2]][1].
- Stall  input  1  pipeline stall; EX inputs are held and must not be consumed.
- BrValid  input  1  EX stage holds a conditional branch.
- BrType  input  3  branch type: 000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez; 110/111 = not a branch.
- BrPC  input  32  PC of the branch.
- BrTarget  input  32  computed taken target.
- BrPredTaken  input  1  prediction carried down the pipeline with the branch.
- Zero  input  1  zero-comparator output.
- Sign  input  1  rs[31].
- Redirect  output  1  registered one-cycle pulse; also serves as the flush of IF/ID and ID/EX.
- RedirectPC  output  32  registered corrected PC, meaningful when Redirect=1.
- BranchCount  output  32  resolved branches, wraps modulo 2^32.
- MissCount  output  32  mispredictions, wraps modulo 2^32.

Behaviour:
- Reset (Rst=1 at edge):
  - Redirect=0, RedirectPC=0, BranchCount=0, MissCount=0.
  - All BHT entries = RESET_CTR.
  - Rst has priority over every other event.
- Resolve condition: accept = BrValid & ~Stall & ~Redirect & BrType<=101.
  - The ~Redirect term is required: an instruction in EX during the redirect cycle is wrong-path and is ignored completely (no counter update, no BHT update).
- Taken evaluation by BrType:
  - beq: Zero
  - bne: ~Zero
  - blez: Sign|Zero
  - bgtz: ~Sign&~Zero
  - bltz: Sign
  - bgez: ~Sign
- No branch delay slot. Fall-through PC = BrPC+4, modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
- Mispredict = accept & (Taken != BrPredTaken).
- At the edge following accept:
  - BranchCount += 1.
  - If mispredict: MissCount += 1; Redirect=1; RedirectPC = Taken ? BrTarget : BrPC+4.
  - Otherwise Redirect=0.
  - BHT[BrPC[IDX_BITS+1:2]] saturates up if Taken (max 11), down if not (min 00).
- Latency: one cycle from accept to the Redirect pulse. Redirect is never high for two consecutive cycles from the same branch.
- Without accept: Redirect=0 next cycle. RedirectPC holds its last value.
- Stall=1: no state changes except a pending Redirect deasserting. The held branch resolves on the first cycle with Stall=0.
- Read/write collision: PredTaken reads the pre-update value when IF_PC indexes the entry being written. There is no bypass.
- BrType 110/111 with BrValid=1: treated as no branch.

Decomposition:
- Shared package mips_branch_pkg holds:
  - BrType encodings (BR_BEQ .. BR_BGEZ, BR_NONE).
  - 2-bit counter constants SNT=00, WNT=01, WT=10, ST=11.
- One natural sub-module, bht_2bit:
  - 2^IDX_BITS array of 2-bit counters.
  - One async read port, one sync saturating-update port, sync reset.
- Taken logic and redirect/counter registers live in the top.

Test Plan:
- Reset, then beq with Zero=1, BrPredTaken=0, BrPC=0x100, BrTarget=0x200 -> next cycle Redirect=1, RedirectPC=0x200, MissCount=1, BHT[0] 01->10; PredTaken for IF_PC=0x100 then reads 1.
- bne with Zero=1, BrPredTaken=1, BrPC=0x0040 -> Redirect=1, RedirectPC=0x0044, MissCount=1; second identical branch in the redirect cycle -> ignored, BranchCount stays 1.
- Sign-based cases with BrPredTaken=0:
  - blez: Sign=0, Zero=1 -> taken, Redirect=1.
  - bgtz: Sign=0, Zero=0 -> taken, Redirect=1.
  - bltz: Sign=0 -> not taken, no Redirect.
  - bgez: Sign=1 -> not taken, no Redirect.
- Correct-prediction saturation: four taken beq at BrPC=0x10, each with BrPredTaken equal to the current PredTaken -> only the first mispredicts; counter ends 11 and stays 11 on the 4th update.
- Stall=1 held 3 cycles with a mispredicting branch, then Stall=0 -> Redirect asserts exactly one cycle after Stall drops; counters increment once.
- Rst asserted in the same cycle as a mispredicting accept -> Redirect=0, counts 0, BHT all 01; BrPC=0xFFFFFFFC not-taken mispredict afterwards -> RedirectPC=0x00000000.
